// File: rtl/video_pkg.sv
// Shared timing defaults, pattern encodings and colour constants for the
// video test-pattern source.
package video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [3:0] {
    PAT_BARS  = 4'd0,
    PAT_GRAD  = 4'd1,
    PAT_CHECK = 4'd2,
    PAT_WHITE = 4'd3
  } pat_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t C_WHITE   = 24'hFFFFFF;
  localparam rgb_t C_YELLOW  = 24'hFFFF00;
  localparam rgb_t C_CYAN    = 24'h00FFFF;
  localparam rgb_t C_GREEN   = 24'h00FF00;
  localparam rgb_t C_MAGENTA = 24'hFF00FF;
  localparam rgb_t C_RED     = 24'hFF0000;
  localparam rgb_t C_BLUE    = 24'h0000FF;
  localparam rgb_t C_BLACK   = 24'h000000;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen_pattern_lut.sv
// Combinational pixel colour lookup for the selected test pattern; returns
// black outside the active region.
module pattern_lut
  import video_pkg::*;
(
  input  logic [3:0] i_pat,
  input  logic [2:0] i_bar_idx,
  input  logic [7:0] i_h_cnt,
  input  logic [7:0] i_v_cnt,
  input  logic       i_active,
  output rgb_t       o_rgb
);

  always_comb begin
    o_rgb = C_BLACK;
    if (i_active) begin
      case (i_pat)
        PAT_BARS:  o_rgb = bar_colour(i_bar_idx);
        PAT_GRAD:  o_rgb = '{r: i_h_cnt, g: i_v_cnt, b: 8'h80};
        PAT_CHECK: o_rgb = (i_h_cnt[5] ^ i_v_cnt[5]) ? C_WHITE : C_BLACK;
        PAT_WHITE: o_rgb = C_WHITE;
        default:   o_rgb = C_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Raster timing generator with registered sync/VDE outputs and a per-frame
// latched test-pattern select.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
)(
  input  logic        clk,
  input  logic        n_rst,
  input  logic [3:0]  sw,
  output logic [23:0] o_vid_data,
  output logic        o_vid_hsync,
  output logic        o_vid_vsync,
  output logic        o_vid_VDE,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // One extra bit so sync end markers equal to the total never overflow.
  localparam logic [HW:0] H_ACT_C = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] H_SS_C  = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] H_SE_C  = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT_C = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] V_SS_C  = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] V_SE_C  = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [3:0]    r_pat;
  logic [2:0]    r_bar_idx;
  logic [BW-1:0] r_bar_px;

  logic w_h_last;
  logic w_v_last;
  logic w_active;
  logic w_hs_on;
  logic w_vs_on;
  logic w_first;
  rgb_t w_rgb;

  assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));
  assign w_active = ({1'b0, r_h_cnt} < H_ACT_C) && ({1'b0, r_v_cnt} < V_ACT_C);
  assign w_hs_on  = ({1'b0, r_h_cnt} >= H_SS_C) && ({1'b0, r_h_cnt} < H_SE_C);
  assign w_vs_on  = ({1'b0, r_v_cnt} >= V_SS_C) && ({1'b0, r_v_cnt} < V_SE_C);
  assign w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_pat     <= '0;
      r_bar_idx <= '0;
      r_bar_px  <= '0;
    end else begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end

      if (w_h_last && w_v_last) begin
        r_pat <= sw;
      end

      // Bar index steps every BAR_W pixels and parks on the last bar.
      if (w_h_last) begin
        r_bar_px  <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_px == BW'(BAR_W - 1)) begin
        r_bar_px <= '0;
        if (r_bar_idx != 3'd7) begin
          r_bar_idx <= r_bar_idx + 1'b1;
        end
      end else begin
        r_bar_px <= r_bar_px + 1'b1;
      end
    end
  end

  pattern_lut u_lut (
    .i_pat     (r_pat),
    .i_bar_idx (r_bar_idx),
    .i_h_cnt   (8'(r_h_cnt)),
    .i_v_cnt   (8'(r_v_cnt)),
    .i_active  (w_active),
    .o_rgb     (w_rgb)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_vid_data    <= '0;
      o_vid_VDE     <= 1'b0;
      o_frame_start <= 1'b0;
      o_vid_hsync   <= ~HS_ON;
      o_vid_vsync   <= ~VS_ON;
    end else begin
      o_vid_data    <= w_rgb;
      o_vid_VDE     <= w_active;
      o_frame_start <= w_first;
      o_vid_hsync   <= w_hs_on ? HS_ON : ~HS_ON;
      o_vid_vsync   <= w_vs_on ? VS_ON : ~VS_ON;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench: reduced raster, randomized pattern-select changes,
// linear-position reference model plus literal pixel/timing expectations.
module tb_video_pattern_gen;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 40, VFP = 3, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;   // 80
  localparam int VT = VA + VFP + VSY + VBP;   // 47
  localparam int FRAME = HT * VT;             // 3760

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  sw;
  logic [23:0] o_vid_data;
  logic        o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .sw            (sw),
    .o_vid_data    (o_vid_data),
    .o_vid_hsync   (o_vid_hsync),
    .o_vid_vsync   (o_vid_vsync),
    .o_vid_VDE     (o_vid_VDE),
    .o_frame_start (o_frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Reference model state: linear pixel position within the frame
  int          m_pos, m_pat;
  bit          m_valid;
  int          exp_pos, exp_pat;
  logic [23:0] exp_data;
  logic        exp_vde, exp_hs, exp_vs, exp_fs;

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s pos=%0d pat=%0d: got %06h, want %06h", name, exp_pos, exp_pat, got, want);
  endtask

  function automatic logic [23:0] model_pix(input int h, input int v, input int pat);
    if (!(h < HA && v < VA)) return 24'h0;
    case (pat)
      0: return bar_tab[h / (HA / 8)];
      1: return 24'(((h % 256) << 16) | ((v % 256) << 8) | 'h80);
      2: return ((((h / 32) % 2) ^ ((v / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h0;
      3: return 24'hFFFFFF;
      default: return 24'h0;
    endcase
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_pos = 0; m_pat = 0; m_valid = 0;
    end else begin
      int h, v;
      h = m_pos % HT;
      v = m_pos / HT;
      exp_pos  = m_pos;
      exp_pat  = m_pat;
      exp_data = model_pix(h, v, m_pat);
      exp_vde  = (h < HA) && (v < VA);
      exp_hs   = !(h >= HA + HFP && h < HA + HFP + HSY);
      exp_vs   = !(v >= VA + VFP && v < VA + VFP + VSY);
      exp_fs   = (m_pos == 0);
      m_valid  = 1;
      if (m_pos == FRAME - 1) m_pat = int'(sw);
      m_pos = (m_pos + 1) % FRAME;
    end
  end

  // Per-frame aggregates measured from the DUT outputs between frame_start pulses
  bit have_fs;
  int gap, vde_acc, hs_acc, vs_acc;

  always @(negedge clk) begin
    if (!n_rst) begin
      check("rst_data",  o_vid_data,    24'h0);
      check("rst_vde",   o_vid_VDE,     24'h0);
      check("rst_fs",    o_frame_start, 24'h0);
      check("rst_hsync", o_vid_hsync,   24'h1);
      check("rst_vsync", o_vid_vsync,   24'h1);
      have_fs = 0;
    end else if (m_valid) begin
      check("data",  o_vid_data,    exp_data);
      check("vde",   o_vid_VDE,     exp_vde);
      check("hsync", o_vid_hsync,   exp_hs);
      check("vsync", o_vid_vsync,   exp_vs);
      check("fs",    o_frame_start, exp_fs);

      if (exp_pat == 0) begin
        case (exp_pos)
          0:  check("bar_px0",   o_vid_data, 24'hFFFFFF);
          8:  check("bar_px8",   o_vid_data, 24'hFFFF00);
          55: check("bar_px55",  o_vid_data, 24'h0000FF);
          56: check("bar_px56",  o_vid_data, 24'h000000);
          64: check("bar_blank", o_vid_data, 24'h000000);
          default: ;
        endcase
      end
      if (exp_pat == 1 && exp_pos == 245) check("grad_5_3", o_vid_data, 24'h050380);
      if (exp_pat == 2) begin
        case (exp_pos)
          32:   check("chk_32_0",  o_vid_data, 24'hFFFFFF);
          2560: check("chk_0_32",  o_vid_data, 24'hFFFFFF);
          2592: check("chk_32_32", o_vid_data, 24'h000000);
          default: ;
        endcase
      end
      if (exp_pat == 9 && exp_pos == 0) check("sw9_px0", o_vid_data, 24'h000000);
      case (exp_pos)
        67:   check("hs_pre",  o_vid_hsync, 24'h1);
        68:   check("hs_on",   o_vid_hsync, 24'h0);
        75:   check("hs_last", o_vid_hsync, 24'h0);
        76:   check("hs_off",  o_vid_hsync, 24'h1);
        3439: check("vs_pre",  o_vid_vsync, 24'h1);
        3440: check("vs_on",   o_vid_vsync, 24'h0);
        3600: check("vs_off",  o_vid_vsync, 24'h1);
        default: ;
      endcase

      if (o_frame_start) begin
        if (have_fs) begin
          check("frame_len", 24'(gap),     24'd3760);
          check("vde_cnt",   24'(vde_acc), 24'd2560);
          check("hs_cnt",    24'(hs_acc),  24'd376);
          check("vs_cnt",    24'(vs_acc),  24'd160);
        end
        have_fs = 1;
        gap = 0; vde_acc = 0; hs_acc = 0; vs_acc = 0;
      end
      gap++;
      vde_acc += int'(o_vid_VDE);
      hs_acc  += int'(!o_vid_hsync);
      vs_acc  += int'(!o_vid_vsync);
    end
  end

  initial begin
    int targets [7];
    int r1, r2;
    targets = '{2, 1, 9, 3, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0};
    n_rst = 1'b0;
    sw    = 4'd0;
    repeat (5) @(negedge clk);
    #2 n_rst = 1'b1;

    // Each frame: junk value, then the intended select, both well inside the frame
    for (int f = 0; f < 7; f++) begin
      r1 = int'($urandom_range(1, FRAME / 3));
      r2 = int'($urandom_range(1, FRAME / 3));
      repeat (r1) @(negedge clk);
      sw = 4'($urandom_range(0, 15));
      repeat (r2) @(negedge clk);
      sw = 4'(targets[f]);
      repeat (FRAME - r1 - r2) @(negedge clk);
    end

    // Mid-frame reset around line 30 of a pattern-0 frame
    repeat (30 * HT + 17) @(negedge clk);
    #2 n_rst = 1'b0;
    sw = 4'd5;
    #1;
    check("async_data",  o_vid_data,    24'h0);
    check("async_vde",   o_vid_VDE,     24'h0);
    check("async_fs",    o_frame_start, 24'h0);
    check("async_hsync", o_vid_hsync,   24'h1);
    check("async_vsync", o_vid_vsync,   24'h1);
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    check("post_rst_fs",   o_frame_start, 24'h1);
    check("post_rst_data", o_vid_data,    24'hFFFFFF);
    repeat (FRAME + 20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
